// File: rtl/bfly_sched_pkg.sv
// Shared definitions for the butterfly job scheduler.
// Watchdog support is built only when BFLY_SCHED_TIMEOUT_EN is defined.
package bfly_sched_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE   = 3'd0;
    localparam logic [STATE_W-1:0] ST_LOAD   = 3'd1;
    localparam logic [STATE_W-1:0] ST_WAIT   = 3'd2;
    localparam logic [STATE_W-1:0] ST_STREAM = 3'd3;
    localparam logic [STATE_W-1:0] ST_DRAIN  = 3'd4;
    localparam logic [STATE_W-1:0] ST_DONE   = 3'd5;

    localparam int DEF_NUM_REQ   = 2;
    localparam int DEF_LEN_W     = 16;
    localparam int DEF_BEAT_W    = 8;
    localparam int DEF_TIMEOUT_W = 12;

endpackage

// File: rtl/bfly_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
// The pointer register lives in the scheduler.
module bfly_rr_arbiter
    import bfly_sched_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/butterfly_job_scheduler.sv
// Shares one butterfly engine among NUM_REQ requesters, one job at a time.
// Define BFLY_SCHED_TIMEOUT_EN to build the per-job watchdog.
module butterfly_job_scheduler
    import bfly_sched_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int LEN_W     = DEF_LEN_W,
    parameter int BEAT_W    = DEF_BEAT_W,
    parameter int TIMEOUT_W = DEF_TIMEOUT_W
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_vld,
    output logic [NUM_REQ-1:0]         req_rdy,
    input  logic [NUM_REQ-1:0]         req_is_fft,
    input  logic [NUM_REQ-1:0]         req_bypass_p2s,
    input  logic [NUM_REQ*LEN_W-1:0]   req_length,
    input  logic [NUM_REQ*BEAT_W-1:0]  req_coef_beats,
    input  logic                       coef_in_vld,
    output logic                       coef_in_rdy,
    output logic                       eng_coef_vld,
    output logic                       eng_is_fft,
    output logic                       eng_is_bypass_p2s,
    output logic [LEN_W-1:0]           eng_length,
    input  logic                       eng_butterfly_start,
    output logic                       up_gate,
    input  logic                       up_fire,
    input  logic                       dn_fire,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] cur_id,
    output logic [NUM_REQ-1:0]         done_vld,
    output logic                       done_err
);

    localparam int ID_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_W < 2 ||
        LEN_W < 1 || BEAT_W < 1) begin : g_bad_param
        $error("butterfly_job_scheduler: parameter out of range");
    end

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] next_state;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    gnt_id;
    logic [ID_W-1:0]    rr_ptr;
    logic [LEN_W-1:0]   gnt_len;
    logic [BEAT_W-1:0]  gnt_beats;
    logic [BEAT_W-1:0]  beats_q;
    logic [BEAT_W-1:0]  beat_cnt;
    logic [LEN_W-1:0]   in_cnt;
    logic [LEN_W-1:0]   out_cnt;
    logic               out_done;
    logic               granted;
    logic               out_phase;

    bfly_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req   (req_vld),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (grant[i]) gnt_id = ID_W'(i);
    end

    assign gnt_len   = req_length[gnt_id*LEN_W +: LEN_W];
    assign gnt_beats = req_coef_beats[gnt_id*BEAT_W +: BEAT_W];
    assign granted   = (state == ST_IDLE) && (|grant);
    assign out_phase = (state == ST_STREAM) || (state == ST_DRAIN);

    // A dn_fire landing in the final DRAIN cycle still counts.
    assign out_done = (out_cnt == eng_length) ||
                      (dn_fire && out_cnt == eng_length - 1'b1);

`ifdef BFLY_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wd_cnt;
    logic                 wd_expire;
    logic                 wd_active;
    logic                 progress;
    logic                 err_q;

    assign wd_active = (state == ST_LOAD) || (state == ST_WAIT) ||
                       out_phase;
    assign progress  = eng_coef_vld | eng_butterfly_start |
                       up_fire | dn_fire;
    assign wd_expire = wd_active && (&wd_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (!wd_active || progress || next_state != state)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
            if (wd_expire)
                err_q <= 1'b1;
            else if (state == ST_DONE)
                err_q <= 1'b0;
        end
    end

    assign done_err = (state == ST_DONE) && err_q;
`else
    assign done_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:
                if (|grant) begin
                    if (gnt_len == '0)        next_state = ST_DONE;
                    else if (gnt_beats == '0) next_state = ST_WAIT;
                    else                      next_state = ST_LOAD;
                end
            ST_LOAD:
                if (coef_in_vld && beat_cnt == beats_q - 1'b1)
                    next_state = ST_WAIT;
            ST_WAIT:
                if (eng_butterfly_start) next_state = ST_STREAM;
            ST_STREAM:
                if (up_fire && in_cnt == eng_length - 1'b1)
                    next_state = ST_DRAIN;
            ST_DRAIN:
                if (out_done) next_state = ST_DONE;
            ST_DONE:
                next_state = ST_IDLE;
            default:
                next_state = ST_IDLE;
        endcase
`ifdef BFLY_SCHED_TIMEOUT_EN
        if (wd_expire) next_state = ST_DONE;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= ST_IDLE;
            rr_ptr            <= '0;
            cur_id            <= '0;
            eng_is_fft        <= 1'b0;
            eng_is_bypass_p2s <= 1'b0;
            eng_length        <= '0;
            beats_q           <= '0;
            beat_cnt          <= '0;
            in_cnt            <= '0;
            out_cnt           <= '0;
            up_gate           <= 1'b0;
        end else begin
            state   <= next_state;
            up_gate <= (next_state == ST_STREAM);
            if (granted) begin
                cur_id            <= gnt_id;
                rr_ptr            <= (gnt_id == ID_W'(NUM_REQ - 1)) ?
                                     '0 : gnt_id + 1'b1;
                eng_is_fft        <= req_is_fft[gnt_id];
                eng_is_bypass_p2s <= req_bypass_p2s[gnt_id];
                eng_length        <= gnt_len;
                beats_q           <= gnt_beats;
                beat_cnt          <= '0;
                in_cnt            <= '0;
                out_cnt           <= '0;
            end
            if (state == ST_LOAD && coef_in_vld)
                beat_cnt <= beat_cnt + 1'b1;
            if (state == ST_STREAM && up_fire)
                in_cnt <= in_cnt + 1'b1;
            if (out_phase && dn_fire && out_cnt != eng_length)
                out_cnt <= out_cnt + 1'b1;
        end
    end

    assign req_rdy      = (state == ST_IDLE) ? grant : '0;
    assign coef_in_rdy  = (state == ST_LOAD);
    assign eng_coef_vld = (state == ST_LOAD) && coef_in_vld;
    assign busy         = (state != ST_IDLE);
    assign done_vld     = (state == ST_DONE) ?
                          (NUM_REQ'(1) << cur_id) : '0;

endmodule

// File: tb/tb_butterfly_job_scheduler.sv
// Directed self-checking bench for butterfly_job_scheduler.
// Watchdog steps follow BFLY_SCHED_TIMEOUT_EN.
module tb_butterfly_job_scheduler;

    localparam int NR = 2;
    localparam int LW = 16;
    localparam int BW = 8;
`ifdef BFLY_SCHED_TIMEOUT_EN
    localparam int TW = 4;
`else
    localparam int TW = 12;
`endif

    logic            clk;
    logic            rst_n;
    logic [NR-1:0]   req_vld;
    logic [NR-1:0]   req_rdy;
    logic [NR-1:0]   req_is_fft;
    logic [NR-1:0]   req_bypass_p2s;
    logic [NR*LW-1:0] req_length;
    logic [NR*BW-1:0] req_coef_beats;
    logic            coef_in_vld;
    logic            coef_in_rdy;
    logic            eng_coef_vld;
    logic            eng_is_fft;
    logic            eng_is_bypass_p2s;
    logic [LW-1:0]   eng_length;
    logic            eng_butterfly_start;
    logic            up_gate;
    logic            up_fire;
    logic            dn_fire;
    logic            busy;
    logic [0:0]      cur_id;
    logic [NR-1:0]   done_vld;
    logic            done_err;

    butterfly_job_scheduler #(
        .NUM_REQ(NR), .LEN_W(LW), .BEAT_W(BW), .TIMEOUT_W(TW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_vld(req_vld), .req_rdy(req_rdy),
        .req_is_fft(req_is_fft), .req_bypass_p2s(req_bypass_p2s),
        .req_length(req_length), .req_coef_beats(req_coef_beats),
        .coef_in_vld(coef_in_vld), .coef_in_rdy(coef_in_rdy),
        .eng_coef_vld(eng_coef_vld), .eng_is_fft(eng_is_fft),
        .eng_is_bypass_p2s(eng_is_bypass_p2s), .eng_length(eng_length),
        .eng_butterfly_start(eng_butterfly_start), .up_gate(up_gate),
        .up_fire(up_fire), .dn_fire(dn_fire), .busy(busy),
        .cur_id(cur_id), .done_vld(done_vld), .done_err(done_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_coef = 0;
    int n_gfire = 0;
    int n_gcyc = 0;
    int n_d0 = 0;
    int n_d1 = 0;

    always @(posedge clk) begin
        if (eng_coef_vld)      n_coef  <= n_coef + 1;
        if (up_gate && up_fire) n_gfire <= n_gfire + 1;
        if (up_gate)           n_gcyc  <= n_gcyc + 1;
        if (done_vld[0])       n_d0    <= n_d0 + 1;
        if (done_vld[1])       n_d1    <= n_d1 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic set_req(input int i, input logic fft, input logic byp,
                           input logic [LW-1:0] len,
                           input logic [BW-1:0] beats);
        req_vld[i]        = 1'b1;
        req_is_fft[i]     = fft;
        req_bypass_p2s[i] = byp;
        req_length[i*LW +: LW]     = len;
        req_coef_beats[i*BW +: BW] = beats;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 50) begin
            tick();
            k++;
        end
        chk(tag, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int s0, s1, s2;
        int k;
        rst_n = 1'b0;
        req_vld = '0;
        req_is_fft = '0;
        req_bypass_p2s = '0;
        req_length = '0;
        req_coef_beats = '0;
        coef_in_vld = 1'b0;
        eng_butterfly_start = 1'b0;
        up_fire = 1'b0;
        dn_fire = 1'b0;
        ticks(3);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_up_gate", {31'd0, up_gate}, 0);
        chk("rst_done", {30'd0, done_vld}, 0);
        chk("rst_len", {16'd0, eng_length}, 0);
        chk("rst_cur_id", {31'd0, cur_id}, 0);
        chk("rst_coef_rdy", {31'd0, coef_in_rdy}, 0);
        #3 rst_n = 1'b1;
        tick();

        // Back-to-back minimal jobs from both requesters.
        s0 = n_d0;
        s1 = n_d1;
        set_req(0, 1'b0, 1'b0, 16'd1, 8'd0);
        set_req(1, 1'b0, 1'b0, 16'd1, 8'd0);
        eng_butterfly_start = 1'b1;
        up_fire = 1'b1;
        dn_fire = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            k = 0;
            while (req_rdy == '0 && k < 20) begin
                tick();
                k++;
            end
            chk("t2_grant", {30'd0, req_rdy}, 32'd1 << (j % 2));
            chk("t2_busy_at_grant", {31'd0, busy}, 0);
            tick();
            if (j == 3) req_vld = '0;
            chk("t2_cur_id", {31'd0, cur_id}, j % 2);
        end
        wait_idle("t2_idle");
        eng_butterfly_start = 1'b0;
        up_fire = 1'b0;
        dn_fire = 1'b0;
        chk("t2_done0", n_d0 - s0, 2);
        chk("t2_done1", n_d1 - s1, 2);

        // Single full job on requester 0.
        set_req(0, 1'b1, 1'b0, 16'd8, 8'd4);
        #1 chk("t1_rdy", {30'd0, req_rdy}, 1);
        tick();
        req_vld = '0;
        #1 chk("t1_rdy_one_cycle", {30'd0, req_rdy}, 0);
        chk("t1_busy", {31'd0, busy}, 1);
        chk("t1_len", {16'd0, eng_length}, 8);
        chk("t1_fft", {31'd0, eng_is_fft}, 1);
        chk("t1_coef_rdy", {31'd0, coef_in_rdy}, 1);
        s0 = n_coef;
        coef_in_vld = 1'b1;
        ticks(4);
        coef_in_vld = 1'b0;
        chk("t1_load_exit", {31'd0, coef_in_rdy}, 0);
        chk("t1_coef_cnt", n_coef - s0, 4);
        ticks(2);
        eng_butterfly_start = 1'b1;
        tick();
        eng_butterfly_start = 1'b0;
        chk("t1_gate_on", {31'd0, up_gate}, 1);
        s1 = n_gfire;
        s2 = n_gcyc;
        up_fire = 1'b1;
        ticks(8);
        up_fire = 1'b0;
        chk("t1_gate_off", {31'd0, up_gate}, 0);
        chk("t1_gate_fires", n_gfire - s1, 8);
        chk("t1_gate_cycles", n_gcyc - s2, 8);
        dn_fire = 1'b1;
        ticks(7);
        chk("t1_not_done", {30'd0, done_vld}, 0);
        tick();
        chk("t1_done", {30'd0, done_vld}, 1);
        chk("t1_err", {31'd0, done_err}, 0);
        dn_fire = 1'b0;
        tick();
        chk("t1_done_pulse", {30'd0, done_vld}, 0);
        chk("t1_idle", {31'd0, busy}, 0);
        chk("t1_len_held", {16'd0, eng_length}, 8);

        // Zero-length job on requester 1.
        s0 = n_coef;
        s1 = n_gcyc;
        set_req(1, 1'b0, 1'b1, 16'd0, 8'd5);
        #1 chk("t3_rdy", {30'd0, req_rdy}, 2);
        tick();
        req_vld = '0;
        chk("t3_done", {30'd0, done_vld}, 2);
        chk("t3_byp", {31'd0, eng_is_bypass_p2s}, 1);
        chk("t3_len", {16'd0, eng_length}, 0);
        tick();
        chk("t3_done_pulse", {30'd0, done_vld}, 0);
        chk("t3_idle", {31'd0, busy}, 0);
        chk("t3_no_coef", n_coef - s0, 0);
        chk("t3_no_gate", n_gcyc - s1, 0);

        // Gappy coefficients plus stray fires.
        set_req(0, 1'b0, 1'b0, 16'd4, 8'd3);
        #1 chk("t4_rdy", {30'd0, req_rdy}, 1);
        tick();
        req_vld = '0;
        s0 = n_coef;
        for (int i = 0; i < 5; i++) begin
            coef_in_vld = (i % 2 == 0);
            tick();
            if (i == 3) chk("t4_load_hold", {31'd0, coef_in_rdy}, 1);
        end
        coef_in_vld = 1'b0;
        chk("t4_load_exit", {31'd0, coef_in_rdy}, 0);
        chk("t4_coef_cnt", n_coef - s0, 3);
        up_fire = 1'b1;
        dn_fire = 1'b1;
        ticks(3);
        up_fire = 1'b0;
        dn_fire = 1'b0;
        chk("t4_wait_gate", {31'd0, up_gate}, 0);
        eng_butterfly_start = 1'b1;
        tick();
        eng_butterfly_start = 1'b0;
        s1 = n_gfire;
        up_fire = 1'b1;
        ticks(3);
        chk("t4_gate_mid", {31'd0, up_gate}, 1);
        tick();
        up_fire = 1'b0;
        chk("t4_gate_off", {31'd0, up_gate}, 0);
        chk("t4_gate_fires", n_gfire - s1, 4);
        dn_fire = 1'b1;
        ticks(3);
        chk("t4_not_done", {30'd0, done_vld}, 0);
        tick();
        chk("t4_done", {30'd0, done_vld}, 1);
        tick();
        dn_fire = 1'b0;
        chk("t4_done_pulse", {30'd0, done_vld}, 0);
        chk("t4_idle", {31'd0, busy}, 0);

        // Withheld engine start.
        set_req(1, 1'b0, 1'b0, 16'd2, 8'd0);
        #1 chk("t5_rdy", {30'd0, req_rdy}, 2);
        tick();
        req_vld = '0;
`ifdef BFLY_SCHED_TIMEOUT_EN
        ticks(15);
        chk("t5_wd_wait", {30'd0, done_vld}, 0);
        chk("t5_wd_busy", {31'd0, busy}, 1);
        tick();
        chk("t5_wd_done", {30'd0, done_vld}, 2);
        chk("t5_wd_err", {31'd0, done_err}, 1);
        tick();
        chk("t5_wd_err_clr", {31'd0, done_err}, 0);
        chk("t5_wd_idle", {31'd0, busy}, 0);
`else
        ticks(100);
        chk("t5_still_busy", {31'd0, busy}, 1);
        chk("t5_no_done", {30'd0, done_vld}, 0);
        chk("t5_no_gate", {31'd0, up_gate}, 0);
        eng_butterfly_start = 1'b1;
        tick();
        eng_butterfly_start = 1'b0;
        chk("t5_gate_on", {31'd0, up_gate}, 1);
        up_fire = 1'b1;
        ticks(2);
        up_fire = 1'b0;
        dn_fire = 1'b1;
        ticks(2);
        chk("t5_done", {30'd0, done_vld}, 2);
        chk("t5_err", {31'd0, done_err}, 0);
        dn_fire = 1'b0;
        tick();
`endif

        // Reset in the middle of streaming.
        s0 = n_d0;
        set_req(0, 1'b1, 1'b1, 16'd6, 8'd0);
        #1 chk("t6_rdy", {30'd0, req_rdy}, 1);
        tick();
        req_vld = '0;
        eng_butterfly_start = 1'b1;
        tick();
        eng_butterfly_start = 1'b0;
        up_fire = 1'b1;
        ticks(3);
        up_fire = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 0);
        chk("t6_rst_gate", {31'd0, up_gate}, 0);
        chk("t6_rst_len", {16'd0, eng_length}, 0);
        chk("t6_rst_cfg", {30'd0, eng_is_fft, eng_is_bypass_p2s}, 0);
        chk("t6_rst_done", {29'd0, done_vld, done_err}, 0);
        ticks(2);
        #3 rst_n = 1'b1;
        tick();
        chk("t6_no_done", n_d0 - s0, 0);
        set_req(1, 1'b0, 1'b0, 16'd2, 8'd1);
        #1 chk("t6_rdy1", {30'd0, req_rdy}, 2);
        tick();
        req_vld = '0;
        coef_in_vld = 1'b1;
        tick();
        coef_in_vld = 1'b0;
        chk("t6_load_exit", {31'd0, coef_in_rdy}, 0);
        eng_butterfly_start = 1'b1;
        tick();
        eng_butterfly_start = 1'b0;
        up_fire = 1'b1;
        ticks(2);
        up_fire = 1'b0;
        dn_fire = 1'b1;
        ticks(2);
        chk("t6_done", {30'd0, done_vld}, 2);
        chk("t6_err", {31'd0, done_err}, 0);
        dn_fire = 1'b0;
        tick();
        chk("t6_idle", {31'd0, busy}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
